// File: rtl/pinmux_pad_attr_ctrl.sv
// Pad-attribute update controller: WARL-legalized shadow registers with a post-write settle window.
// Optional per-pad sticky lock enabled by defining PINMUX_PAD_ATTR_LOCK_EN.
module pinmux_pad_attr_ctrl #(
  parameter int NumPads      = 4,
  parameter int AttrW        = 8,
  parameter int PadType      = 1,
  parameter int SettleCycles = 3,
  localparam int PadW        = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic [PadW-1:0]          req_pad_i,
  input  logic [AttrW-1:0]         req_attr_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [AttrW-1:0]         rsp_attr_o,
  output logic                     rsp_err_o,
  output logic [NumPads*AttrW-1:0] attr_o,
  output logic                     busy_o
);

  localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'((SettleCycles > 0) ? SettleCycles - 1 : 0);
  localparam logic [AttrW-1:0] LegalMask = (PadType == 1) ? AttrW'('h3F) :
                                           (PadType == 2) ? AttrW'('h0F) : '0;

  typedef enum logic [1:0] {IDLE, APPLY, SETTLE, RESP} state_t;

  state_t            state;
  logic [CntW-1:0]   cnt;
  logic [AttrW-1:0]  attr_q [NumPads];
  logic [AttrW-1:0]  rsp_attr_q;
  logic              rsp_err_q;
  logic [PadW-1:0]   pad_q;
  logic [AttrW-1:0]  wdata_q;
  logic              pad_ok;
`ifdef PINMUX_PAD_ATTR_LOCK_EN
  logic [NumPads-1:0] lock_q;
`endif

  function automatic logic [AttrW-1:0] legalize(input logic [AttrW-1:0] v);
    return v & LegalMask;
  endfunction

  assign pad_ok = 32'(req_pad_i) < NumPads;

  // Request fields are plain data, captured on the accept edge without reset
  always_ff @(posedge clk_i) begin
    if (state == IDLE && req_valid_i) begin
      pad_q   <= req_pad_i;
      wdata_q <= req_attr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_attr_q <= '0;
      rsp_err_q  <= 1'b0;
      for (int p = 0; p < NumPads; p++) attr_q[p] <= '0;
`ifdef PINMUX_PAD_ATTR_LOCK_EN
      lock_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (!pad_ok) begin
              rsp_attr_q <= '0;
              rsp_err_q  <= 1'b1;
              state      <= RESP;
            end else if (!req_write_i) begin
              rsp_attr_q <= attr_q[req_pad_i];
              rsp_err_q  <= 1'b0;
              state      <= RESP;
`ifdef PINMUX_PAD_ATTR_LOCK_EN
            end else if (lock_q[req_pad_i]) begin
              rsp_attr_q <= attr_q[req_pad_i];
              rsp_err_q  <= 1'b1;
              state      <= RESP;
`endif
            end else begin
              state <= APPLY;
            end
          end
        end
        APPLY: begin
          attr_q[pad_q] <= legalize(wdata_q);
          rsp_attr_q    <= legalize(wdata_q);
          rsp_err_q     <= 1'b0;
`ifdef PINMUX_PAD_ATTR_LOCK_EN
          if (wdata_q[AttrW-1]) lock_q[pad_q] <= 1'b1;
`endif
          if (SettleCycles == 0) begin
            state <= RESP;
          end else begin
            cnt   <= CntInit;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    attr_o = '0;
    for (int p = 0; p < NumPads; p++) attr_o[p*AttrW +: AttrW] = attr_q[p];
  end

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state == APPLY) || (state == SETTLE);
  assign rsp_valid_o = (state == RESP);
  assign rsp_attr_o  = rsp_attr_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
